inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
Parametrised successor to the current PC/fetch stage. Generates sequential PCs, issues in-order requests to instruction memory and buffers returned instructions with their PCs in a DEPTH-entry prefetch queue feeding decode. Adds back-pressure from decode, branch redirect, and a flush input (clr) that discards both queued and in-flight fetches. Sits between the I-memory port and the decode stage of the RISC-V core.

Parameters:
XLEN, 32, address and instruction width in bits
DEPTH, 4, prefetch queue entries; power of two, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset
MAX_OUTST, DEPTH, maximum memory requests in flight; at most DEPTH

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
clr  in  1  flush; discard queue and in-flight responses, keep PC
redirect_valid  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  XLEN  redirect target, bits [1:0] ignored (forced 0)
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (word-aligned)
imem_gnt  in  1  memory accepts request this cycle (req && gnt = issued)
imem_rvalid  in  1  in-order response valid
imem_rdata  in  XLEN  returned instruction word
out_valid  out  1  queue head valid toward decode
out_ready  in  1  decode accepts head (valid && ready = pop)
out_ins  out  XLEN  head instruction
out_pc  out  XLEN  PC of head instruction
final_ins_addr  out  XLEN  next fetch PC (debug/compat, equals imem_addr)

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0; imem_req=0, out_valid=0, out_ins=0, out_pc=0 during and one cycle after reset; imem_addr=final_ins_addr=RESET_PC. rst overrides clr and redirect.
- Credit: imem_req=1 iff (count + outstanding) < DEPTH and outstanding < MAX_OUTST and no clr/redirect this cycle. Guarantees every response has a free slot; no response is ever dropped for lack of space.
- Issue: req&&gnt -> outstanding+1, fetch_pc += 4 (wraps modulo 2^XLEN). Each issued PC is pushed into a PC side-FIFO (DEPTH entries) to pair with its response.
- Response: rvalid -> if discard>0, discard-1 and response dropped (PC side-FIFO entry popped); else write {pc, rdata} to queue tail. outstanding-1 in either case. rvalid with outstanding=0 is a protocol error: assertion, ignored.
- Pop: out_valid&&out_ready -> head advances. Simultaneous push and pop allowed, count unchanged. Head data stable while out_valid&&!out_ready.
- Latency: minimum request-to-out_valid = memory latency + 1 cycle (registered queue output); no combinational path rvalid->out_valid.
- Redirect: redirect_valid at edge -> fetch_pc=redirect_pc&~3, queue emptied, discard=outstanding minus any response arriving same cycle (that response also discarded), no request issued that cycle. Next cycle issues redirect target.
- clr: identical to redirect except fetch_pc unchanged (refetch from current next-PC). clr and redirect same cycle: redirect wins for PC, flush effects identical.
- Pop in the same cycle as flush/redirect: pop ignored, queue empty afterwards.
- Full: count=DEPTH -> out_valid=1, imem_req=0. Empty: out_valid=0, out_ins/out_pc hold last values.
- Pointers: log2(DEPTH) bits plus wrap bit; count derived, range 0..DEPTH.

Decomposition:
- Package rv_fetch_pkg: XLEN default, RESET_PC default, INST_NOP (32'h0000_0013), fetch_entry_t {pc, ins}.
- One sub-module: sync_fifo (parametrised width/depth, push/pop/full/empty/count, synchronous active-high clear), instantiated twice: PC side-FIFO and instruction queue.

Test Plan:
- Reset then gnt=1, 1-cycle memory, out_ready=1 -> imem_addr 0,4,8,C... one per cycle; out_pc 0 with out_ins=mem[0] two cycles after first request; final_ins_addr matches imem_addr.
- out_ready=0, DEPTH=4 -> exactly 4 requests issued, imem_req drops, out_valid=1 with out_pc=0 held; release ready -> pcs 0,4,8,C popped in order, fetch resumes at 0x10.
- 3 requests outstanding (3-cycle memory), redirect_pc=0x0000_0103 -> next imem_addr=0x100; 3 stale responses dropped; first out_pc=0x100.
- clr with queue holding pcs 0x20,0x24 and 1 outstanding -> queue empty, 1 response discarded, refetch continues from 0x2C.
- fetch_pc=0xFFFF_FFFC issued -> next imem_addr=0x0000_0000 (wrap).
- rst asserted mid-stream with outstanding=2 and clr=1 -> imem_req=0, out_valid=0, imem_addr=RESET_PC; late rvalid pulses ignored, no queue write.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared constants and types for the instruction fetch path.
package rv_fetch_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, derived count and a synchronous clear.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
  assign do_push = push && !clr && (!full || pop);
  assign do_pop  = pop && !clr && !empty;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited in-order I-memory requests
// and a prefetch queue of {pc, ins} toward decode, with redirect and flush.
module inst_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter int              DEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter int              MAX_OUTST = DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_ins,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] final_ins_addr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic              rst_q;
  logic              flush;
  logic              issue;
  logic              resp;
  logic              resp_keep;
  logic              q_pop;
  logic [CW:0]       in_use;

  logic [XLEN-1:0]   pc_head;
  logic              pc_full;
  logic              pc_empty;
  logic [CW-1:0]     pc_count;

  logic [2*XLEN-1:0] q_push_data;
  logic [2*XLEN-1:0] q_head;
  logic [2*XLEN-1:0] hold_entry;
  logic [2*XLEN-1:0] head_sel;
  logic              q_full;
  logic              q_empty;
  logic [CW-1:0]     q_count;

  assign flush     = clr || redirect_valid;
  assign in_use    = {1'b0, q_count} + {1'b0, outstanding};
  assign issue     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outstanding != '0);
  assign resp_keep = resp && (discard == '0) && !flush;
  assign q_pop     = out_valid && out_ready && !flush;

  // Queue slots are reserved at request time, so every response always has room.
  assign imem_req = !rst && !rst_q && !flush
                    && (in_use < (CW+1)'(DEPTH))
                    && (outstanding < CW'(MAX_OUTST));

  assign imem_addr      = rst ? RESET_PC : fetch_pc;
  assign final_ins_addr = imem_addr;

  assign out_valid = !rst && !q_empty;
  assign head_sel  = q_empty ? hold_entry : q_head;
  assign out_pc    = rst ? '0 : head_sel[2*XLEN-1:XLEN];
  assign out_ins   = rst ? '0 : head_sel[XLEN-1:0];

  assign q_push_data = {pc_head, imem_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      rst_q       <= 1'b1;
      hold_entry  <= '0;
    end else begin
      rst_q       <= 1'b0;
      outstanding <= outstanding + CW'(issue) - CW'(resp);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~XLEN'(3);
      end else if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      // On flush every request still in flight becomes stale, including one answering now.
      if (flush) begin
        discard <= outstanding - CW'(resp);
      end else if (resp && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (!q_empty) hold_entry <= q_head;
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (1'b0),
    .push      (issue),
    .push_data (fetch_pc),
    .pop       (resp),
    .pop_data  (pc_head),
    .full      (pc_full),
    .empty     (pc_empty),
    .count     (pc_count)
  );

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (resp_keep),
    .push_data (q_push_data),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding == '0)));
  a_pc_fifo_tracks: assert property (@(posedge clk) disable iff (rst)
    pc_count == outstanding);
  a_pc_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(issue && pc_full));
  a_pc_fifo_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(resp && pc_empty));
  a_full_blocks_req: assert property (@(posedge clk) disable iff (rst)
    !(q_full && imem_req));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized directed-step bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

  localparam int          XLEN      = 32;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic            clk;
  logic            rst;
  logic            clr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_ins;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] final_ins_addr;

  inst_fetch_queue #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ins        (out_ins),
    .out_pc         (out_pc),
    .final_ins_addr (final_ins_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Step knobs: gnt/ready modes are 0 = low, 1 = high, 2 = random.
  bit          k_rst;
  bit          k_clr;
  bit          k_redir;
  bit          force_rvalid;
  logic [31:0] k_redir_pc;
  int          gnt_mode;
  int          ready_mode;
  int          lat_lo;
  int          lat_hi;

  // Reference model: queued {pc, ins}, in-flight {stale, pc}, next fetch PC, last shown head.
  logic [31:0] exp_pc;
  logic [63:0] model_q[$];
  logic [32:0] inflight[$];
  logic [63:0] hold;
  bit          prev_rst;

  // Memory environment: in-order responses with per-request due cycles.
  int          mem_due[$];
  logic [31:0] mem_addr[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    rst            = k_rst;
    clr            = k_clr;
    redirect_valid = k_redir;
    redirect_pc    = k_redir_pc;
    imem_gnt       = (gnt_mode == 1) ? 1'b1 : (gnt_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
    out_ready      = (ready_mode == 1) ? 1'b1 : (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (force_rvalid) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memWord(mem_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic stepCycle();
    bit          flush;
    bit          exp_req;
    bit          exp_ovalid;
    bit          issue;
    logic [63:0] head;
    logic [32:0] e;
    int          due;
    @(negedge clk);
    cyc++;
    applyStimulus();
    #1;
    flush      = k_clr || k_redir;
    exp_req    = !k_rst && !prev_rst && !flush
                 && (model_q.size() + inflight.size() < DEPTH)
                 && (inflight.size() < MAX_OUTST);
    exp_ovalid = !k_rst && (model_q.size() > 0);
    head       = k_rst ? 64'h0 : (model_q.size() > 0 ? model_q[0] : hold);
    checkOutput("imem_req", 32'(imem_req), 32'(exp_req));
    checkOutput("imem_addr", imem_addr, k_rst ? RESET_PC : exp_pc);
    checkOutput("final_ins_addr", final_ins_addr, k_rst ? RESET_PC : exp_pc);
    checkOutput("out_valid", 32'(out_valid), 32'(exp_ovalid));
    checkOutput("out_pc", out_pc, head[63:32]);
    checkOutput("out_ins", out_ins, head[31:0]);

    if (k_rst) begin
      exp_pc = RESET_PC;
      model_q.delete();
      inflight.delete();
      mem_due.delete();
      mem_addr.delete();
      hold = 64'h0;
    end else begin
      if (model_q.size() > 0) hold = model_q[0];
      issue = exp_req && imem_gnt;
      if (exp_ovalid && out_ready && !flush) void'(model_q.pop_front());
      if (imem_rvalid && inflight.size() > 0) begin
        e = inflight.pop_front();
        void'(mem_due.pop_front());
        void'(mem_addr.pop_front());
        if (!e[32] && !flush) model_q.push_back({e[31:0], imem_rdata});
      end
      if (flush) begin
        model_q.delete();
        foreach (inflight[i]) inflight[i][32] = 1'b1;
      end
      if (issue) begin
        inflight.push_back({1'b0, exp_pc});
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (mem_due.size() > 0 && due <= mem_due[$]) due = mem_due[$] + 1;
        mem_due.push_back(due);
        mem_addr.push_back(exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (k_redir) exp_pc = k_redir_pc & ~32'h3;
    end
    prev_rst = k_rst;
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepCycle();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
    k_rst = 1'b1; k_clr = 1'b0; k_redir = 1'b0; force_rvalid = 1'b0; k_redir_pc = '0;
    gnt_mode = 0; ready_mode = 1; lat_lo = 1; lat_hi = 1;
    exp_pc = RESET_PC; hold = 64'h0; prev_rst = 1'b1;

    $display("[TB] reset");
    runCycles(3);
    k_rst = 1'b0;

    $display("[TB] streaming with 1-cycle memory");
    gnt_mode = 1;
    runCycles(12);

    $display("[TB] decode back-pressure fills the queue");
    ready_mode = 0;
    runCycles(10);
    ready_mode = 1;
    runCycles(10);

    $display("[TB] redirect with requests in flight");
    lat_lo = 3; lat_hi = 3;
    runCycles(6);
    k_redir = 1'b1; k_redir_pc = 32'h0000_0103;
    runCycles(1);
    k_redir = 1'b0;
    runCycles(12);

    $display("[TB] flush with queued and in-flight fetches");
    lat_lo = 2; lat_hi = 2; ready_mode = 0;
    runCycles(5);
    k_clr = 1'b1;
    runCycles(1);
    k_clr = 1'b0; ready_mode = 1;
    runCycles(10);

    $display("[TB] PC wrap at top of address space");
    lat_lo = 1; lat_hi = 1;
    k_redir = 1'b1; k_redir_pc = 32'hFFFF_FFF8;
    runCycles(1);
    k_redir = 1'b0;
    runCycles(8);

    $display("[TB] randomized traffic");
    gnt_mode = 2; ready_mode = 2; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 400; i++) begin
      k_clr      = ($urandom_range(0, 39) == 0);
      k_redir    = ($urandom_range(0, 39) == 0);
      k_redir_pc = $urandom;
      stepCycle();
    end
    k_clr = 1'b0; k_redir = 1'b0;

    $display("[TB] reset mid-stream with clr and late responses");
    gnt_mode = 1; ready_mode = 0; lat_lo = 3; lat_hi = 3;
    runCycles(3);
    k_rst = 1'b1; k_clr = 1'b1; force_rvalid = 1'b1;
    runCycles(2);
    k_rst = 1'b0; k_clr = 1'b0; force_rvalid = 1'b0;
    gnt_mode = 0; ready_mode = 1;
    runCycles(4);
    gnt_mode = 1; lat_lo = 1; lat_hi = 2;
    runCycles(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
